// File: rtl/meas_sched_pkg.sv
// meas_sched_pkg: shared timebase defaults, widths and FSM encoding for the measurement scheduler
package meas_sched_pkg;
  localparam int DIV_4M_DEF  = 3;
  localparam int DIV_5MS_DEF = 20000;
  localparam int GATE_W_DEF  = 8;
  localparam int FCNT_W_DEF  = 16;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GATE  = 2'd1,
    S_LATCH = 2'd2,
    S_REQ   = 2'd3
  } state_t;
endpackage

// File: rtl/timebase_ce.sv
// timebase_ce: free-running prescaler and tick counter producing registered ce_4mhz / tick_5ms strobes
module timebase_ce import meas_sched_pkg::*; #(
  parameter int DIV_4M  = DIV_4M_DEF,
  parameter int DIV_5MS = DIV_5MS_DEF
) (
  input  logic clk_12mhz,
  input  logic reset,
  output logic ce_4mhz,
  output logic tick_5ms
);
  localparam int PW = (DIV_4M > 1) ? $clog2(DIV_4M) : 1;
  localparam int TW = (DIV_5MS > 1) ? $clog2(DIV_5MS) : 1;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          w_ce_nxt;
  // Strobes are decoded from next-state so they are flops yet coincide with the terminal counts.
  always_comb begin
    w_pre_nxt = (r_pre == PW'(DIV_4M - 1)) ? '0 : r_pre + 1'b1;
    w_ce_nxt  = w_pre_nxt == PW'(DIV_4M - 1);
    w_cnt_nxt = !ce_4mhz ? r_cnt : (r_cnt == TW'(DIV_5MS - 1)) ? '0 : r_cnt + 1'b1;
  end
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      r_pre    <= '0;
      r_cnt    <= '0;
      ce_4mhz  <= 1'b0;
      tick_5ms <= 1'b0;
    end else begin
      r_pre    <= w_pre_nxt;
      r_cnt    <= w_cnt_nxt;
      ce_4mhz  <= w_ce_nxt;
      tick_5ms <= w_ce_nxt && (w_cnt_nxt == TW'(DIV_5MS - 1));
    end
  end
endmodule

// File: rtl/meas_cycle_scheduler.sv
// meas_cycle_scheduler: opens tick-aligned counting gates, latches results and hands frames to readout
module meas_cycle_scheduler import meas_sched_pkg::*; #(
  parameter int DIV_4M  = DIV_4M_DEF,
  parameter int DIV_5MS = DIV_5MS_DEF,
  parameter int GATE_W  = GATE_W_DEF,
  parameter int FCNT_W  = FCNT_W_DEF
) (
  input  logic              clk_12mhz,
  input  logic              reset,
  input  logic              enable,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              frame_ack,
  output logic              ce_4mhz,
  output logic              tick_5ms,
  output logic              gate,
  output logic              latch,
  output logic              frame_req,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overrun
);
  state_t            r_state, w_state_nxt;
  logic [GATE_W-1:0] r_rem, w_rem_nxt;
  logic              r_en_d;
  logic              w_ack;
  logic              w_ovr_nxt;
  timebase_ce #(.DIV_4M(DIV_4M), .DIV_5MS(DIV_5MS)) u_timebase (
    .clk_12mhz(clk_12mhz),
    .reset    (reset),
    .ce_4mhz  (ce_4mhz),
    .tick_5ms (tick_5ms)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_ack       = (r_state == S_REQ) && frame_ack;
    case (r_state)
      S_IDLE: if (enable && tick_5ms) begin
        w_state_nxt = S_GATE;
        w_rem_nxt   = (gate_len == '0) ? GATE_W'(1) : gate_len;
      end
      S_GATE: if (!enable) w_state_nxt = S_IDLE;
        else if (tick_5ms) begin
          if (r_rem <= GATE_W'(1)) w_state_nxt = S_LATCH;
          else w_rem_nxt = r_rem - 1'b1;
        end
      S_LATCH: w_state_nxt = S_REQ;
      S_REQ:   if (frame_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A missed tick outranks a simultaneous re-enable so the loss is never hidden.
    w_ovr_nxt = ((r_state == S_REQ) && tick_5ms && !frame_ack) ? 1'b1 :
                (enable && !r_en_d) ? 1'b0 : overrun;
  end
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_en_d    <= 1'b0;
      gate      <= 1'b0;
      latch     <= 1'b0;
      frame_req <= 1'b0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_en_d    <= enable;
      gate      <= w_state_nxt == S_GATE;
      latch     <= w_state_nxt == S_LATCH;
      frame_req <= w_state_nxt == S_REQ;
      frame_cnt <= frame_cnt + FCNT_W'(w_ack);
      overrun   <= w_ovr_nxt;
    end
  end
endmodule

// File: tb/tb_meas_cycle_scheduler.sv
// tb_meas_cycle_scheduler: randomized scenarios checked every cycle against a tick-arithmetic model
module tb_meas_cycle_scheduler;
  localparam int D4 = 3;
  localparam int D5 = 8;
  localparam int P  = D4 * D5;
  logic       clk_12mhz = 1'b0;
  logic       reset, enable, frame_ack;
  logic [7:0] gate_len;
  logic       ce_4mhz, tick_5ms, gate, latch, frame_req, overrun;
  logic [3:0] frame_cnt;
  logic [9:0] obs;
  int         cyc, m_cnt, total, bad;
  meas_cycle_scheduler #(.DIV_4M(D4), .DIV_5MS(D5), .GATE_W(8), .FCNT_W(4)) dut (
    .clk_12mhz(clk_12mhz),
    .reset    (reset),
    .enable   (enable),
    .gate_len (gate_len),
    .frame_ack(frame_ack),
    .ce_4mhz  (ce_4mhz),
    .tick_5ms (tick_5ms),
    .gate     (gate),
    .latch    (latch),
    .frame_req(frame_req),
    .frame_cnt(frame_cnt),
    .overrun  (overrun)
  );
  always #5 clk_12mhz = ~clk_12mhz;
  assign obs = {ce_4mhz, tick_5ms, gate, latch, frame_req, overrun, frame_cnt};
  always @(posedge clk_12mhz or posedge reset) cyc <= reset ? 0 : cyc + 1;
  // Timebase strobes follow directly from the edge count since reset release.
  function automatic logic [9:0] ev(input logic g, input logic l, input logic r, input logic o);
    return {cyc % D4 == D4 - 1, cyc % P == P - 1, g, l, r, o, 4'(m_cnt)};
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    frame_ack = 1'b0;
    repeat (2) @(negedge clk_12mhz);
    reset = 1'b0;
    m_cnt = 0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    frame_ack = 1'b0;
    gate_len = 8'd0;
    #3;
    if (obs !== 10'd0) begin
      $display("FAIL reset_state got=%b exp=%b", obs, 10'd0);
      bad++;
    end
    total++;
    @(negedge clk_12mhz);
    reset = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk_12mhz);
      if (obs !== ev(0, 0, 0, 0)) begin
        $display("FAIL idle_timebase cyc=%0d got=%b exp=%b", cyc, obs, ev(0, 0, 0, 0));
        bad++;
      end
      total++;
    end
  endtask
  task automatic test_frames(input int n, input bit rnd);
    enable = 1'b1;
    frame_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      int len, d, s, e, fin;
      logic [9:0] x;
      len = !rnd ? 0 : (i == 0) ? 2 : (i == 1) ? 0 : int'($urandom_range(0, 3));
      d = !rnd ? 1 : (i == 0) ? 5 : (i == 2) ? P - 1 : int'($urandom_range(1, P - 1));
      gate_len = 8'(len);
      s = cyc + P - cyc % P;
      e = s + ((len == 0) ? 1 : len) * P;
      fin = e + 1 + d;
      while (cyc < fin) begin
        @(negedge clk_12mhz);
        if (cyc == fin) m_cnt++;
        x = ev(cyc >= s && cyc < e, cyc == e, cyc > e && cyc < fin, 1'b0);
        if (obs !== x) begin
          $display("FAIL frame%0d len=%0d d=%0d cyc=%0d got=%b exp=%b", i, len, d, cyc, obs, x);
          bad++;
        end
        total++;
        if (cyc == s + 1) gate_len = 8'($urandom);
        frame_ack = (cyc == fin - 1);
      end
    end
  endtask
  task automatic test_overrun();
    int s, e, ov, fin, c1;
    logic [9:0] x;
    enable = 1'b1;
    gate_len = 8'd1;
    s = cyc + P - cyc % P;
    e = s + P;
    ov = s + 2 * P;
    fin = e + 1 + int'($urandom_range(P + 1, 2 * P));
    while (cyc < fin) begin
      @(negedge clk_12mhz);
      if (cyc == fin) m_cnt++;
      x = ev(cyc >= s && cyc < e, cyc == e, cyc > e && cyc < fin, cyc >= ov);
      if (obs !== x) begin
        $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, obs, x);
        bad++;
      end
      total++;
      frame_ack = (cyc == fin - 1);
    end
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk_12mhz);
      if (obs !== ev(0, 0, 0, 1)) begin
        $display("FAIL overrun_sticky cyc=%0d got=%b exp=%b", cyc, obs, ev(0, 0, 0, 1));
        bad++;
      end
      total++;
    end
    c1 = cyc;
    enable = 1'b1;
    @(negedge clk_12mhz);
    x = ev(c1 % P == P - 1, 0, 0, 0);
    if (obs !== x) begin
      $display("FAIL overrun_clear cyc=%0d got=%b exp=%b", cyc, obs, x);
      bad++;
    end
    total++;
  endtask
  task automatic test_enable_drop();
    int s, cd;
    logic [9:0] x;
    enable = 1'b1;
    gate_len = 8'd4;
    s = cyc + P - cyc % P;
    cd = s + int'($urandom_range(P, 3 * P));
    while (cyc < s + 5 * P) begin
      @(negedge clk_12mhz);
      x = ev(cyc >= s && cyc <= cd, 0, 0, 0);
      if (obs !== x) begin
        $display("FAIL enable_drop cyc=%0d got=%b exp=%b", cyc, obs, x);
        bad++;
      end
      total++;
      if (cyc == cd) enable = 1'b0;
    end
  endtask
  task automatic test_async_reset();
    int k;
    test_frames(15, 1'b0);
    gate_len = 8'd0;
    k = 0;
    while (!frame_req && k < 4 * P) begin
      @(negedge clk_12mhz);
      k++;
    end
    if (!frame_req || frame_cnt !== 4'hF) begin
      $display("FAIL reach_req got_req=%b got_cnt=%h exp_req=1 exp_cnt=f", frame_req, frame_cnt);
      bad++;
    end
    total++;
    #2;
    reset = 1'b1;
    #1;
    if (obs !== 10'd0) begin
      $display("FAIL async_reset got=%b exp=%b", obs, 10'd0);
      bad++;
    end
    total++;
    enable = 1'b0;
    frame_ack = 1'b0;
    @(negedge clk_12mhz);
    reset = 1'b0;
    m_cnt = 0;
    @(negedge clk_12mhz);
    if (obs !== ev(0, 0, 0, 0)) begin
      $display("FAIL after_reset cyc=%0d got=%b exp=%b", cyc, obs, ev(0, 0, 0, 0));
      bad++;
    end
    total++;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end
  initial begin
    total = 0;
    bad = 0;
    test_reset();
    do_reset();
    test_frames(6, 1'b1);
    do_reset();
    test_overrun();
    do_reset();
    test_enable_drop();
    do_reset();
    test_frames(17, 1'b0);
    do_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
